// File: rtl/arb_requester_if.sv
// Handshake bundle between an arb_requester and its client/arbiter side.
// slave is the requester's view; master is the driving side.
interface arb_requester_if;
    logic start;
    logic gnt;
    logic req;
    logic busy;
    logic active;
    logic done;
    logic timeout;
    logic abort;

    modport master (
        output start,
        output gnt,
        input  req,
        input  busy,
        input  active,
        input  done,
        input  timeout,
        input  abort
    );

    modport slave (
        input  start,
        input  gnt,
        output req,
        output busy,
        output active,
        output done,
        output timeout,
        output abort
    );
endinterface

// File: rtl/arb_requester.sv
// Client-side front end for a two-way round-robin arbiter: request, wait for grant,
// own the resource for BURST_LEN cycles, then release with a one-cycle req gap.
module arb_requester #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic           clk,
    input  logic           rst,
    arb_requester_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StReq, StOwn, StRel} state_e;

    localparam logic [7:0] BurstLast = 8'(BURST_LEN - 1);
    localparam logic [7:0] WaitLast  = 8'(TIMEOUT - 1);
    localparam bit         TimeoutEn = (TIMEOUT != 0);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] own_cnt_q, own_cnt_d;
    logic       req_q, req_d;
    logic       busy_q, busy_d;
    logic       active_q, active_d;
    logic       done_q, done_d;
    logic       timeout_q, timeout_d;
    logic       abort_q, abort_d;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        own_cnt_d  = own_cnt_q;
        timeout_d  = 1'b0;
        abort_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d    = StReq;
                    wait_cnt_d = '0;
                end
            end
            StReq: begin
                // A grant on the final wait edge beats the timeout.
                if (bus.gnt) begin
                    state_d   = StOwn;
                    own_cnt_d = BurstLast;
                end else if (TimeoutEn && (wait_cnt_q == WaitLast)) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else if (wait_cnt_q != 8'hFF) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StOwn: begin
                if (!bus.gnt) begin
                    state_d = StIdle;
                    abort_d = 1'b1;
                end else if (own_cnt_q == 8'd0) begin
                    state_d = StRel;
                end else begin
                    own_cnt_d = own_cnt_q - 8'd1;
                end
            end
            StRel: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered copies of the next-state decode.
        req_d    = (state_d == StReq) || (state_d == StOwn);
        busy_d   = (state_d != StIdle);
        active_d = (state_d == StOwn);
        done_d   = (state_d == StRel);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            own_cnt_q  <= '0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            own_cnt_q  <= own_cnt_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            active_q   <= active_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            abort_q    <= abort_d;
        end
    end

    assign bus.req     = req_q;
    assign bus.busy    = busy_q;
    assign bus.active  = active_q;
    assign bus.done    = done_q;
    assign bus.timeout = timeout_q;
    assign bus.abort   = abort_q;

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: single-client scenarios against hand-computed
// cycle tables, plus two requester pairs sharing a round-robin arbiter model.
module tb_arb_requester;

    logic clk;
    logic rst;
    logic start_r;
    logic gnt_man;
    logic follow;
    logic req_dly;
    logic pair_start;
    logic [1:0] own_a, own_b, last_a, last_b;

    int n_pass;
    int n_checks;

    // Per-cycle stimulus and expected {req,busy,active,done,timeout,abort}.
    logic [5:0] exp_q[$];
    logic       st_q[$];
    logic       gn_q[$];

    arb_requester_if m_if ();
    arb_requester_if pa1_if ();
    arb_requester_if pa2_if ();
    arb_requester_if pb1_if ();
    arb_requester_if pb2_if ();

    arb_requester #(.BURST_LEN(4), .TIMEOUT(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (m_if)
    );
    arb_requester #(.BURST_LEN(4), .TIMEOUT(16)) u_pa1 (
        .clk (clk),
        .rst (rst),
        .bus (pa1_if)
    );
    arb_requester #(.BURST_LEN(4), .TIMEOUT(16)) u_pa2 (
        .clk (clk),
        .rst (rst),
        .bus (pa2_if)
    );
    arb_requester #(.BURST_LEN(12), .TIMEOUT(0)) u_pb1 (
        .clk (clk),
        .rst (rst),
        .bus (pb1_if)
    );
    arb_requester #(.BURST_LEN(12), .TIMEOUT(0)) u_pb2 (
        .clk (clk),
        .rst (rst),
        .bus (pb2_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) req_dly <= m_if.req;

    assign m_if.start   = start_r;
    assign m_if.gnt     = follow ? req_dly : gnt_man;
    assign pa1_if.start = pair_start;
    assign pa2_if.start = pair_start;
    assign pb1_if.start = pair_start;
    assign pb2_if.start = pair_start;
    assign pa1_if.gnt   = (own_a == 2'd1);
    assign pa2_if.gnt   = (own_a == 2'd2);
    assign pb1_if.gnt   = (own_b == 2'd1);
    assign pb2_if.gnt   = (own_b == 2'd2);

    // Registered round-robin arbiter: owner keeps grant until its req drops.
    function automatic logic [1:0] rr_next(input logic [1:0] own, input logic [1:0] last,
                                           input logic r1, input logic r2);
        if (own == 2'd1) return r1 ? 2'd1 : 2'd0;
        if (own == 2'd2) return r2 ? 2'd2 : 2'd0;
        if (r1 && r2) return (last == 2'd1) ? 2'd2 : 2'd1;
        if (r1) return 2'd1;
        if (r2) return 2'd2;
        return 2'd0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            own_a  <= 2'd0;
            last_a <= 2'd2;
        end else begin
            own_a <= rr_next(own_a, last_a, pa1_if.req, pa2_if.req);
            if (own_a == 2'd0 && rr_next(own_a, last_a, pa1_if.req, pa2_if.req) != 2'd0)
                last_a <= rr_next(own_a, last_a, pa1_if.req, pa2_if.req);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            own_b  <= 2'd0;
            last_b <= 2'd2;
        end else begin
            own_b <= rr_next(own_b, last_b, pb1_if.req, pb2_if.req);
            if (own_b == 2'd0 && rr_next(own_b, last_b, pb1_if.req, pb2_if.req) != 2'd0)
                last_b <= rr_next(own_b, last_b, pb1_if.req, pb2_if.req);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] m_outs();
        return {m_if.req, m_if.busy, m_if.active, m_if.done, m_if.timeout, m_if.abort};
    endfunction

    // {req,busy,active,done,timeout,abort} of pair client k (a1, a2, b1, b2).
    function automatic logic [5:0] pair_outs(input int k);
        case (k)
            0: return {pa1_if.req, pa1_if.busy, pa1_if.active, pa1_if.done, pa1_if.timeout,
                       pa1_if.abort};
            1: return {pa2_if.req, pa2_if.busy, pa2_if.active, pa2_if.done, pa2_if.timeout,
                       pa2_if.abort};
            2: return {pb1_if.req, pb1_if.busy, pb1_if.active, pb1_if.done, pb1_if.timeout,
                       pb1_if.abort};
            default: return {pb2_if.req, pb2_if.busy, pb2_if.active, pb2_if.done,
                             pb2_if.timeout, pb2_if.abort};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int n, input logic s, input logic g, input logic [5:0] e);
        repeat (n) begin
            st_q.push_back(s);
            gn_q.push_back(g);
            exp_q.push_back(e);
        end
    endtask

    // Entry i drives the inputs sampled on edge i and checks the outputs after it.
    task automatic run_seq(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            start_r = st_q[i];
            gnt_man = gn_q[i];
            tick();
            check($sformatf("%s c%0d", tag, i), 32'(m_outs()), 32'(exp_q[i]));
        end
        start_r = 1'b0;
        gnt_man = 1'b0;
        exp_q.delete();
        st_q.delete();
        gn_q.delete();
        tick();
    endtask

    task automatic load_basic();
        push(1, 1'b1, 1'b0, 6'b110000);
        push(1, 1'b0, 1'b0, 6'b110000);
        push(4, 1'b0, 1'b0, 6'b111000);
        push(1, 1'b0, 1'b0, 6'b010100);
        push(1, 1'b0, 1'b0, 6'b000000);
    endtask

    int act[4];
    int dn_cnt[4];
    int dn_cyc[4];
    int ovl_a, ovl_b, to_cnt, ab_cnt;

    initial begin
        n_pass     = 0;
        n_checks   = 0;
        rst        = 1'b1;
        start_r    = 1'b0;
        gnt_man    = 1'b0;
        follow     = 1'b0;
        pair_start = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset main", 32'(m_outs()), 32'd0);
        for (int k = 0; k < 4; k++) check($sformatf("reset pair%0d", k), 32'(pair_outs(k)), 32'd0);

        // gnt follows req one cycle late.
        follow = 1'b1;
        load_basic();
        run_seq("basic");
        follow = 1'b0;

        push(1, 1'b1, 1'b0, 6'b110000);
        push(7, 1'b0, 1'b0, 6'b110000);
        push(1, 1'b0, 1'b0, 6'b000010);
        push(1, 1'b0, 1'b0, 6'b000000);
        run_seq("timeout");

        // Grant arrives on the edge where wait_cnt==7.
        push(1, 1'b1, 1'b0, 6'b110000);
        push(7, 1'b0, 1'b0, 6'b110000);
        push(4, 1'b0, 1'b1, 6'b111000);
        push(1, 1'b0, 1'b1, 6'b010100);
        push(1, 1'b0, 1'b0, 6'b000000);
        run_seq("gnt_last");

        push(1, 1'b1, 1'b0, 6'b110000);
        push(2, 1'b0, 1'b1, 6'b111000);
        push(1, 1'b0, 1'b0, 6'b000001);
        push(1, 1'b0, 1'b0, 6'b000000);
        run_seq("abort");

        // start pulses on REQ, OWN and REL edges.
        push(1, 1'b1, 1'b0, 6'b110000);
        push(2, 1'b1, 1'b1, 6'b111000);
        push(2, 1'b0, 1'b1, 6'b111000);
        push(1, 1'b1, 1'b1, 6'b010100);
        push(1, 1'b1, 1'b0, 6'b000000);
        push(2, 1'b0, 1'b0, 6'b000000);
        run_seq("start_ign");

        // Two requester pairs, each sharing one arbiter.
        for (int k = 0; k < 4; k++) begin
            act[k]    = 0;
            dn_cnt[k] = 0;
            dn_cyc[k] = -1;
        end
        ovl_a  = 0;
        ovl_b  = 0;
        to_cnt = 0;
        ab_cnt = 0;
        pair_start = 1'b1;
        for (int c = 0; c < 34; c++) begin
            tick();
            pair_start = 1'b0;
            if (pa1_if.active && pa2_if.active) ovl_a++;
            if (pb1_if.active && pb2_if.active) ovl_b++;
            for (int k = 0; k < 4; k++) begin
                if (pair_outs(k)[3]) act[k]++;
                if (pair_outs(k)[2]) begin
                    dn_cnt[k]++;
                    dn_cyc[k] = c;
                end
                if (pair_outs(k)[1]) to_cnt++;
                if (pair_outs(k)[0]) ab_cnt++;
            end
        end
        check("pairA overlap", 32'(ovl_a), 32'd0);
        check("pairB overlap", 32'(ovl_b), 32'd0);
        check("pair timeouts", 32'(to_cnt), 32'd0);
        check("pair aborts", 32'(ab_cnt), 32'd0);
        check("a1 active", 32'(act[0]), 32'd4);
        check("a2 active", 32'(act[1]), 32'd4);
        check("b1 active", 32'(act[2]), 32'd12);
        check("b2 active", 32'(act[3]), 32'd12);
        for (int k = 0; k < 4; k++) check($sformatf("pair%0d dones", k), 32'(dn_cnt[k]), 32'd1);
        check("a1 done cyc", 32'(dn_cyc[0]), 32'd6);
        check("a2 done cyc", 32'(dn_cyc[1]), 32'd13);
        check("b1 done cyc", 32'(dn_cyc[2]), 32'd14);
        check("b2 done cyc", 32'(dn_cyc[3]), 32'd29);

        // Asynchronous reset landing mid-OWN, between clock edges.
        start_r = 1'b1;
        gnt_man = 1'b1;
        tick();
        start_r = 1'b0;
        tick();
        tick();
        check("pre_rst own", 32'(m_outs()), 32'(6'b111000));
        #2;
        rst = 1'b1;
        #1;
        check("rst async", 32'(m_outs()), 32'd0);
        gnt_man = 1'b0;
        tick();
        check("rst held", 32'(m_outs()), 32'd0);
        rst = 1'b0;
        tick();
        follow = 1'b1;
        load_basic();
        run_seq("post_rst");
        follow = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
- Client-side front end for the two-way round-robin ARBITER; one instance drives each reqN/gntN pair.
- Turns a one-cycle start pulse into a well-formed request, waits for the grant and holds ownership for a fixed burst.
- Releases the request with a guaranteed one-cycle gap, and reports completion, timeout or loss of grant.

Parameters:
- BURST_LEN, 4: cycles of ownership per transaction. Range 1..255.
- TIMEOUT, 16: maximum cycles spent waiting for the grant before giving up. 0 disables the timeout. Range 0..255.

Ports:
- clk  input  1  system clock; all sampling on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a transaction. Sampled only in IDLE; ignored in any other state.
- gnt  input  1  grant from the arbiter (connects to gnt1 or gnt2).
- req  output  1  request to the arbiter (connects to req1 or req2).
- busy  output  1  high in any state other than IDLE.
- active  output  1  high while this client owns the resource (OWN state).
- done  output  1  one-cycle pulse: burst completed normally.
- timeout  output  1  one-cycle pulse: the grant never arrived.
- abort  output  1  one-cycle pulse: the grant was withdrawn during OWN.

Behaviour:
- All outputs are registered. There are no combinational input-to-output paths.
- Reset: rst=1 immediately forces state to IDLE, clears both counters, and drives req, busy, active, done, timeout and abort to 0. This applies at any point, including mid-burst. The first edge after rst falls is a normal IDLE edge.
- State register uses four states: IDLE, REQ, OWN, REL.
- Counters: wait_cnt is 8 bits and own_cnt is 8 bits. Neither counter ever wraps; both saturate by construction through the state exits below.
- IDLE:
  - req=0, busy=0, active=0.
  - On an edge with start=1, go to REQ and clear wait_cnt. req and busy are 1 from the following cycle, so the latency is 1 cycle.
- REQ:
  - req=1, busy=1, active=0.
  - Edge with gnt=1: go to OWN and load own_cnt=BURST_LEN-1. active=1 from the next cycle.
  - Edge with gnt=0, TIMEOUT!=0 and wait_cnt==TIMEOUT-1: go to IDLE. timeout=1 for the next cycle and req=0 in that same cycle.
  - Edge with gnt=0 otherwise: increment wait_cnt.
  - Precedence: gnt=1 on the timeout edge wins, so the client enters OWN and no timeout is reported.
- OWN:
  - req=1, busy=1, active=1.
  - Edge with gnt=0: go to IDLE. abort=1 for the next cycle; req and active fall in that same cycle.
  - Edge with gnt=1 and own_cnt==0: go to REL.
  - Edge with gnt=1 otherwise: decrement own_cnt.
  - Result: active is high for exactly BURST_LEN cycles when the grant is held throughout.
- REL:
  - req=0, active=0, busy=1, done=1. This state lasts exactly 1 cycle and then returns to IDLE unconditionally.
  - start during REL is ignored.
  - The one-cycle req=0 gap lets the arbiter hand over to the other client.
- Pulse shape: done, timeout and abort are mutually exclusive, never wider than 1 cycle, and are 0 whenever their condition is absent.
- gnt asserted while in IDLE or REL has no effect.
- A new transaction is accepted at the earliest on the edge after the pulse cycle. Back-to-back bursts therefore show req low for at least 2 cycles.

Test Plan:
- Basic burst (BURST_LEN=4, TIMEOUT=8):
  - Stimulus: reset, then start pulse at edge 0; gnt tied to req delayed 1 cycle.
  - Required: req rises after edge 0, active high for exactly 4 cycles, req and active fall together, done high 1 cycle, busy low on the following cycle.
- Timeout:
  - Stimulus: start pulse with gnt held 0.
  - Required: req high for exactly 8 cycles, then req=0 and timeout=1 for 1 cycle; done, active and abort are never 1.
- Grant on the last wait cycle:
  - Stimulus: gnt=1 on the same edge where wait_cnt==7.
  - Required: enters OWN, active for 4 cycles, done pulse, timeout stays 0.
- Abort:
  - Stimulus: grant held 2 cycles into OWN, then dropped.
  - Required: req and active fall on the next cycle with abort=1 for 1 cycle; done=0.
- Two instances on ARBITER:
  - Stimulus: start both instances on the same edge.
  - Required: exactly one active at a time, never both. The second client gets the grant after the first one's REL gap and both report done. Repeat with TIMEOUT=0 and confirm no timeout ever fires.
- Async reset mid-OWN:
  - Stimulus: assert rst between clock edges.
  - Required: all outputs 0 immediately, without waiting for a clock edge. A start pulse after rst falls runs a clean burst.
- Start ignored:
  - Stimulus: start pulses during REQ, OWN and REL.
  - Required: no second transaction occurs and busy returns to 0 after the single done pulse.
